// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl
//   Register-file write-back sequencer for the multicycle MIPS datapath.
//   Takes a decoded instruction class from the main control FSM and, cycle by
//   cycle, drives the regDest mux select, the write-data source select and the
//   register-file write enable. It waits on memory for LOAD/PUSH/POP, performs
//   two writes for POP, never writes $zero, and flags memory timeouts and
//   illegal classes.
//
// Parameters
//   MEM_TIMEOUT : consecutive MEMWAIT cycles with mem_ready low before the
//                 operation is aborted (1..255)
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   start      in   request pulse, accepted only while busy=0
//   op_class   in   instruction class, sampled with start
//   rt, rd     in   register fields, sampled with start
//   mem_ready  in   memory access complete (looked at only in MEMWAIT)
//   reg_dest   out  00 rt, 01 rd, 10 $31, 11 $29
//   wb_src     out  00 ALU, 01 MEM, 10 PC
//   reg_write  out  register-file write enable
//   busy       out  high whenever not idle
//   done       out  one-cycle completion pulse
//   err        out  coincident with done on timeout or illegal class

module regfile_wb_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] op_class,
  input  logic [4:0] rt,
  input  logic [4:0] rd,
  input  logic       mem_ready,
  output logic [1:0] reg_dest,
  output logic [1:0] wb_src,
  output logic       reg_write,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MEMWAIT = 3'd1,
    WB1     = 3'd2,
    WB2     = 3'd3,
    FIN     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_R    = 3'b000,
    CLS_IALU = 3'b001,
    CLS_LOAD = 3'b010,
    CLS_JAL  = 3'b011,
    CLS_PUSH = 3'b100,
    CLS_POP  = 3'b101,
    CLS_NOWB = 3'b110,
    CLS_ILL  = 3'b111
  } op_class_t;

  localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

  localparam logic [1:0] SEL_RT  = 2'b00;
  localparam logic [1:0] SEL_RD  = 2'b01;
  localparam logic [1:0] SEL_31  = 2'b10;
  localparam logic [1:0] SEL_29  = 2'b11;
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_MEM = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;

  state_t    state, nstate;
  op_class_t cls, ncls;
  logic [4:0] rt_q, nrt;
  logic [4:0] rd_q, nrd;
  logic [7:0] cnt, ncnt;
  logic       tmo, ntmo;

  logic [1:0] nsel, nsrc;
  logic       nwe, nbusy, ndone, nerr;

  // Next-state and latched-field update.
  always_comb begin
    nstate = state;
    ncls   = cls;
    nrt    = rt_q;
    nrd    = rd_q;
    ncnt   = cnt;
    ntmo   = tmo;
    case (state)
      IDLE: begin
        if (start) begin
          ncls = op_class_t'(op_class);
          nrt  = rt;
          nrd  = rd;
          ncnt = '0;
          ntmo = 1'b0;
          case (op_class_t'(op_class))
            CLS_R, CLS_IALU, CLS_JAL:    nstate = WB1;
            CLS_LOAD, CLS_PUSH, CLS_POP: nstate = MEMWAIT;
            default:                     nstate = FIN;
          endcase
        end
      end
      MEMWAIT: begin
        if (mem_ready) begin
          nstate = WB1;
          ncnt   = '0;
        end else if (cnt + 8'd1 == TMO_LIMIT) begin
          nstate = FIN;
          ncnt   = '0;
          ntmo   = 1'b1;
        end else begin
          ncnt = cnt + 8'd1;
        end
      end
      WB1:     nstate = (cls == CLS_POP) ? WB2 : FIN;
      WB2:     nstate = FIN;
      FIN:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and next latched fields, then
  // registered, so each output appears in the same cycle as its state with
  // no path from the inputs to the pins.
  always_comb begin
    nsel  = SEL_RT;
    nsrc  = SRC_ALU;
    nwe   = 1'b0;
    nbusy = (nstate != IDLE);
    ndone = 1'b0;
    nerr  = 1'b0;
    case (nstate)
      WB1: begin
        case (ncls)
          CLS_R:    begin nsel = SEL_RD; nsrc = SRC_ALU; end
          CLS_IALU: begin nsel = SEL_RT; nsrc = SRC_ALU; end
          CLS_LOAD: begin nsel = SEL_RT; nsrc = SRC_MEM; end
          CLS_JAL:  begin nsel = SEL_31; nsrc = SRC_PC;  end
          CLS_PUSH: begin nsel = SEL_29; nsrc = SRC_ALU; end
          CLS_POP:  begin nsel = SEL_RT; nsrc = SRC_MEM; end
          default:  begin nsel = SEL_RT; nsrc = SRC_ALU; end
        endcase
        nwe = 1'b1;
      end
      WB2: begin
        nsel = SEL_29;
        nsrc = SRC_ALU;
        nwe  = 1'b1;
      end
      FIN: begin
        ndone = 1'b1;
        nerr  = ntmo || (ncls == CLS_ILL);
      end
      default: ;
    endcase
    // $zero is never written; the sequence itself is unaffected.
    if ((nsel == SEL_RT && nrt == 5'd0) || (nsel == SEL_RD && nrd == 5'd0))
      nwe = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cls       <= CLS_R;
      rt_q      <= '0;
      rd_q      <= '0;
      cnt       <= '0;
      tmo       <= 1'b0;
      reg_dest  <= '0;
      wb_src    <= '0;
      reg_write <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= nstate;
      cls       <= ncls;
      rt_q      <= nrt;
      rd_q      <= nrd;
      cnt       <= ncnt;
      tmo       <= ntmo;
      reg_dest  <= nsel;
      wb_src    <= nsrc;
      reg_write <= nwe;
      busy      <= nbusy;
      done      <= ndone;
      err       <= nerr;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

  localparam int unsigned MT = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op_class = '0;
  logic [4:0] rt = '0;
  logic [4:0] rd = '0;
  logic       mem_ready = 1'b0;
  logic [1:0] reg_dest, wb_src;
  logic       reg_write, busy, done, err;

  regfile_wb_ctrl #(.MEM_TIMEOUT(MT)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_class(op_class),
    .rt(rt), .rd(rd), .mem_ready(mem_ready), .reg_dest(reg_dest),
    .wb_src(wb_src), .reg_write(reg_write), .busy(busy), .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  // Packed view: {reg_dest, wb_src, reg_write, busy, done, err}
  function automatic logic [7:0] outs();
    return {reg_dest, wb_src, reg_write, busy, done, err};
  endfunction

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rt;
    logic [4:0]  rd;
    int unsigned k;        // MEMWAIT cycle with mem_ready high, 0 = never
    int unsigned mem_cyc;  // expected MEMWAIT cycles
    logic        has_wb1;
    logic        has_wb2;
    logic [1:0]  d1;
    logic [1:0]  s1;
    logic        we1;
    logic        we2;
    logic        e;
  } vec_t;

  function automatic vec_t mk(logic [2:0] op, logic [4:0] rtv, logic [4:0] rdv,
                              int unsigned k, int unsigned mc, logic h1, logic h2,
                              logic [1:0] d1, logic [1:0] s1, logic we1,
                              logic we2, logic e);
    vec_t v;
    v.op = op; v.rt = rtv; v.rd = rdv; v.k = k; v.mem_cyc = mc;
    v.has_wb1 = h1; v.has_wb2 = h2; v.d1 = d1; v.s1 = s1;
    v.we1 = we1; v.we2 = we2; v.e = e;
    return v;
  endfunction

  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b required %b ({dest,src,we,busy,done,err})", name, act, expv);
    end
  endtask

  // Expected per-cycle outputs from T+1 to the first idle cycle after FIN.
  task automatic build_expect(input vec_t v);
    exp_q.delete();
    for (int unsigned c = 0; c < v.mem_cyc; c++) exp_q.push_back(8'b0000_0100);
    if (v.has_wb1) exp_q.push_back({v.d1, v.s1, v.we1, 3'b100});
    if (v.has_wb2) exp_q.push_back({2'b11, 2'b00, v.we2, 3'b100});
    exp_q.push_back({5'b00000, 2'b11, v.e});
    exp_q.push_back(8'h00);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input logic pre_ready);
    int n;
    @(negedge clk);
    start = 1'b1; op_class = v.op; rt = v.rt; rd = v.rd; mem_ready = pre_ready;
    build_expect(v);
    n = exp_q.size();
    @(posedge clk);
    #1;
    start = 1'b0; mem_ready = 1'b0;
    op_class = 3'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    for (int c = 1; c <= n; c++) begin
      mem_ready = (v.k != 0 && c == int'(v.k));
      @(negedge clk);
      check($sformatf("%s_T+%0d", tag, c), outs(), exp_q.pop_front());
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
  endtask

  vec_t vt[15];
  int   writes;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(3'b000, 5'd3, 5'd5,  0, 0,  1, 0, 2'b01, 2'b00, 1, 0, 0);
    vt[1]  = mk(3'b000, 5'd3, 5'd0,  0, 0,  1, 0, 2'b01, 2'b00, 0, 0, 0);
    vt[2]  = mk(3'b001, 5'd7, 5'd0,  0, 0,  1, 0, 2'b00, 2'b00, 1, 0, 0);
    vt[3]  = mk(3'b001, 5'd0, 5'd9,  0, 0,  1, 0, 2'b00, 2'b00, 0, 0, 0);
    vt[4]  = mk(3'b010, 5'd9, 5'd0,  1, 1,  1, 0, 2'b00, 2'b01, 1, 0, 0);
    vt[5]  = mk(3'b010, 5'd0, 5'd4,  2, 2,  1, 0, 2'b00, 2'b01, 0, 0, 0);
    vt[6]  = mk(3'b011, 5'd0, 5'd0,  0, 0,  1, 0, 2'b10, 2'b10, 1, 0, 0);
    vt[7]  = mk(3'b100, 5'd0, 5'd0,  3, 3,  1, 0, 2'b11, 2'b00, 1, 0, 0);
    vt[8]  = mk(3'b101, 5'd8, 5'd0,  3, 3,  1, 1, 2'b00, 2'b01, 1, 1, 0);
    vt[9]  = mk(3'b101, 5'd0, 5'd6,  4, 4,  1, 1, 2'b00, 2'b01, 0, 1, 0);
    vt[10] = mk(3'b110, 5'd4, 5'd4,  0, 0,  0, 0, 2'b00, 2'b00, 0, 0, 0);
    vt[11] = mk(3'b111, 5'd4, 5'd4,  0, 0,  0, 0, 2'b00, 2'b00, 0, 0, 1);
    vt[12] = mk(3'b010, 5'd9, 5'd0,  0, MT, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    vt[13] = mk(3'b101, 5'd8, 5'd0,  0, MT, 0, 0, 2'b00, 2'b00, 0, 0, 1);
    vt[14] = mk(3'b000, 5'd0, 5'd31, 0, 0,  1, 0, 2'b01, 2'b00, 1, 0, 0);

    // Reset state, with inputs active during reset.
    #1 reset_n = 1'b0;
    start = 1'b1; mem_ready = 1'b1; op_class = 3'b000; rd = 5'd5;
    #2 check("reset_async", outs(), 8'h00);
    repeat (2) begin
      @(negedge clk);
      check("reset_held", outs(), 8'h00);
    end
    start = 1'b0; mem_ready = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check("after_release", outs(), 8'h00);

    for (int i = 0; i < 15; i++)
      run_vec($sformatf("vec%0d", i), vt[i], 1'b0);

    // mem_ready pulsed in IDLE must not be remembered.
    @(negedge clk) mem_ready = 1'b1;
    @(negedge clk) check("idle_ready_ignored", outs(), 8'h00);
    run_vec("ready_not_kept", mk(3'b010, 5'd9, 5'd0, 2, 2, 1, 0, 2'b00, 2'b01, 1, 0, 0), 1'b1);

    // start held high: second acceptance at the edge ending T+3.
    @(negedge clk);
    start = 1'b1; op_class = 3'b000; rt = 5'd3; rd = 5'd5;
    exp_q.delete();
    exp_q.push_back(8'b0100_1100);
    exp_q.push_back(8'b0000_0110);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'b0100_1100);
    exp_q.push_back(8'b0000_0110);
    exp_q.push_back(8'h00);
    writes = 0;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c <= 3 && reg_write === 1'b1) writes++;
      check($sformatf("busy_hold_T+%0d", c), outs(), exp_q.pop_front());
      @(posedge clk);
      #1;
      if (c == 4) start = 1'b0;
    end
    n_checks++;
    if (writes != 1) begin
      n_fail++;
      $display("FAIL busy_hold_writes: got %0d writes required 1", writes);
    end

    // Reset dropped during POP WB1.
    @(negedge clk);
    start = 1'b1; op_class = 3'b101; rt = 5'd8; rd = 5'd0;
    @(posedge clk);
    #1 start = 1'b0; mem_ready = 1'b1;
    @(negedge clk) check("rst_mid_memwait", outs(), 8'b0000_0100);
    @(posedge clk);
    #1 mem_ready = 1'b0;
    @(negedge clk) check("rst_mid_wb1", outs(), 8'b0001_1100);
    #2 reset_n = 1'b0;
    #1 check("rst_mid_immediate", outs(), 8'h00);
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_mid_idle%0d", c), outs(), 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
